// File: rtl/wb_pkg.sv
// Shared types for the writeback buffer: FSM states, entry layout and
// line/tag widths derived from the default 32-bit word and 16-byte line.
package wb_pkg;

  localparam int unsigned WB_DATA_WIDTH  = 32;
  localparam int unsigned WB_OFFSET_BITS = 4;
  localparam int unsigned LINE_WIDTH     = 4 * WB_DATA_WIDTH;
  localparam int unsigned TAG_WIDTH      = WB_DATA_WIDTH - WB_OFFSET_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } wb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] line;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Age-priority tag comparator: walks occupied entries from head (oldest) to
// newest and reports the newest valid entry whose tag matches.
module wb_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          EXCLUDE_HEAD = 1'b0,
  localparam int unsigned PW          = $clog2(DEPTH)
) (
  input  wb_entry_t            entries [DEPTH],
  input  logic [PW-1:0]        head,
  input  logic [PW:0]          count,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 hit,
  output logic [PW-1:0]        idx
);

  logic [PW-1:0] pos;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + k[PW-1:0];
      // Later (younger) matches overwrite earlier ones, so the newest wins.
      if ((k < 32'(count)) && !(EXCLUDE_HEAD && (k == 0)) &&
          entries[pos].valid && (entries[pos].tag == tag)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Dirty-line eviction FIFO between the data cache and data_mem, with
// in-place coalescing, refill forwarding and a flush/drain handshake.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_valid,
  input  logic [DATA_WIDTH-1:0]     wb_addr,
  input  logic [4*DATA_WIDTH-1:0]   wb_data,
  output logic                      wb_ready,
  output logic                      mem_wr_en,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [4*DATA_WIDTH-1:0]   mem_data,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     lookup_addr,
  output logic                      lookup_hit,
  output logic [4*DATA_WIDTH-1:0]   lookup_data,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  if ((4*DATA_WIDTH != LINE_WIDTH) || (DATA_WIDTH-OFFSET_BITS != TAG_WIDTH)) begin : g_width_check
    $error("writeback_buffer: DATA_WIDTH/OFFSET_BITS disagree with wb_pkg entry layout");
  end

  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   cnt;
  wb_state_t     state;

  logic [TAG_WIDTH-1:0] wb_tag, lookup_tag;
  logic                 coal_hit;
  logic [PW-1:0]        coal_idx, lookup_idx;
  logic                 accept, enq, deq;

  assign wb_tag     = wb_addr[DATA_WIDTH-1:OFFSET_BITS];
  assign lookup_tag = lookup_addr[DATA_WIDTH-1:OFFSET_BITS];

  wb_match #(.DEPTH(DEPTH), .EXCLUDE_HEAD(1'b1)) u_coalesce (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .tag     (wb_tag),
    .hit     (coal_hit),
    .idx     (coal_idx)
  );

  wb_match #(.DEPTH(DEPTH), .EXCLUDE_HEAD(1'b0)) u_lookup (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .tag     (lookup_tag),
    .hit     (lookup_hit),
    .idx     (lookup_idx)
  );

  // flush_req also blocks acceptance in its own cycle, so an eviction
  // arriving alongside the flush pulse is refused rather than slipped in.
  assign wb_ready  = (state == IDLE) && !flush_req && ((cnt < FULL) || coal_hit);
  assign accept    = wb_valid && wb_ready;
  assign enq       = accept && !coal_hit;
  assign mem_wr_en = (cnt != '0);
  assign deq       = mem_wr_en && mem_ready;

  assign mem_addr    = mem_wr_en ? {entries[head].tag, {OFFSET_BITS{1'b0}}} : '0;
  assign mem_data    = mem_wr_en ? entries[head].line : '0;
  assign lookup_data = lookup_hit ? entries[lookup_idx].line : '0;
  assign flush_done  = (state == FLUSH) && (cnt == '0);
  assign count       = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      state        <= IDLE;
      err_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (accept && coal_hit) begin
        entries[coal_idx].line <= wb_data;
      end
      if (enq) begin
        entries[tail] <= '{valid: 1'b1, tag: wb_tag, line: wb_data};
        tail          <= tail + PW'(1);
      end
      if (deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end

      unique case ({enq, deq})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase

      if (wb_valid && !wb_ready) begin
        err_overflow <= 1'b1;
      end

      unique case (state)
        IDLE:    if (flush_req) state <= FLUSH;
        FLUSH:   if (cnt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: a queue-based reference model is
// compared against every output on each falling edge, plus literal checks.
module tb_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_valid;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         wb_ready;
  logic         mem_wr_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_ready;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         flush_req;
  logic         flush_done;
  logic [2:0]   count;
  logic         err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_buffer #(.DATA_WIDTH(32), .DEPTH(4), .OFFSET_BITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of buffered lines, oldest first.
  typedef struct {
    logic [27:0]  tag;
    logic [127:0] line;
  } m_entry_t;

  m_entry_t q[$];
  bit       m_flush;
  bit       m_err;

  function automatic int m_coal_idx();
    for (int i = q.size() - 1; i >= 1; i--)
      if (q[i].tag == wb_addr[31:4]) return i;
    return -1;
  endfunction

  function automatic int m_look_idx();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].tag == lookup_addr[31:4]) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    return !m_flush && !flush_req && ((q.size() < 4) || (m_coal_idx() >= 0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int ci;
    bit rdy, acc, dq;
    if (!rst_n) begin
      q.delete();
      m_flush = 1'b0;
      m_err   = 1'b0;
    end else begin
      rdy = m_ready();
      ci  = m_coal_idx();
      acc = wb_valid && rdy;
      dq  = (q.size() > 0) && mem_ready;
      if (wb_valid && !rdy) m_err = 1'b1;
      if (m_flush) begin
        if (q.size() == 0) m_flush = 1'b0;
      end else if (flush_req) begin
        m_flush = 1'b1;
      end
      if (acc && ci >= 0) q[ci].line = wb_data;
      if (dq) void'(q.pop_front());
      if (acc && ci < 0) q.push_back('{wb_addr[31:4], wb_data});
    end
  end

  always @(negedge clk) begin
    int li;
    li = m_look_idx();
    chk("count",        128'(count),        128'(q.size()));
    chk("wb_ready",     128'(wb_ready),     128'(m_ready()));
    chk("mem_wr_en",    128'(mem_wr_en),    128'(q.size() > 0));
    chk("mem_addr",     128'(mem_addr),     (q.size() > 0) ? 128'({q[0].tag, 4'h0}) : 128'd0);
    chk("mem_data",     mem_data,           (q.size() > 0) ? q[0].line : 128'd0);
    chk("lookup_hit",   128'(lookup_hit),   128'(li >= 0));
    chk("lookup_data",  lookup_data,        (li >= 0) ? q[li].line : 128'd0);
    chk("flush_done",   128'(flush_done),   128'(m_flush && (q.size() == 0)));
    chk("err_overflow", 128'(err_overflow), 128'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic evict(input logic [31:0] a, input logic [127:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    for (int i = 0; i < 10 && count != 0; i++) step();
    chk("lit_drain_empty", 128'(count), 128'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    mem_ready   = 1'b0;
    lookup_addr = '0;
    flush_req   = 1'b0;
    step();
    chk("lit_rst_count", 128'(count),        128'd0);
    chk("lit_rst_wr_en", 128'(mem_wr_en),    128'd0);
    chk("lit_rst_addr",  128'(mem_addr),     128'd0);
    chk("lit_rst_hit",   128'(lookup_hit),   128'd0);
    chk("lit_rst_err",   128'(err_overflow), 128'd0);
    rst_n = 1'b1;
    step();

    // Three evictions held back, then drained in order.
    evict(32'h100, 128'hD1);
    evict(32'h200, 128'hD2);
    evict(32'h300, 128'hD3);
    chk("lit_t1_count", 128'(count),    128'd3);
    chk("lit_t1_head",  128'(mem_addr), 128'h100);
    mem_ready = 1'b1;
    step();
    chk("lit_t1_addr2", 128'(mem_addr), 128'h200);
    chk("lit_t1_data2", mem_data,       128'hD2);
    step();
    chk("lit_t1_addr3", 128'(mem_addr), 128'h300);
    step();
    chk("lit_t1_empty", 128'(count),     128'd0);
    chk("lit_t1_wr_en", 128'(mem_wr_en), 128'd0);
    mem_ready = 1'b0;

    // Full buffer: new address overflows, non-head match coalesces.
    evict(32'h100, 128'hE1);
    evict(32'h200, 128'hE2);
    evict(32'h300, 128'hE3);
    evict(32'h400, 128'hE4);
    wb_valid = 1'b1;
    wb_addr  = 32'h500;
    wb_data  = 128'hEE;
    #1;
    chk("lit_t2_full_ready", 128'(wb_ready), 128'd0);
    step();
    wb_valid = 1'b0;
    chk("lit_t2_err",   128'(err_overflow), 128'd1);
    chk("lit_t2_count", 128'(count),        128'd4);
    wb_valid = 1'b1;
    wb_addr  = 32'h300;
    wb_data  = 128'hE5;
    #1;
    chk("lit_t2_coal_ready", 128'(wb_ready), 128'd1);
    step();
    wb_valid    = 1'b0;
    lookup_addr = 32'h308;
    #1;
    chk("lit_t2_coal_count", 128'(count),       128'd4);
    chk("lit_t2_coal_data",  lookup_data,       128'hE5);
    lookup_addr = '0;
    drain();

    // Coalesce into a non-head entry; lookup hit/miss.
    evict(32'h10, 128'hF0);
    evict(32'h40, 128'hAAAA);
    evict(32'h80, 128'hCCCC);
    evict(32'h48, 128'hBBBB);
    chk("lit_t3_count", 128'(count), 128'd3);
    lookup_addr = 32'h44;
    #1;
    chk("lit_t3_hit",  128'(lookup_hit), 128'd1);
    chk("lit_t3_data", lookup_data,      128'hBBBB);
    lookup_addr = 32'hC0;
    #1;
    chk("lit_t3_miss",      128'(lookup_hit), 128'd0);
    chk("lit_t3_miss_data", lookup_data,      128'd0);
    lookup_addr = '0;
    drain();

    // Head match allocates a second entry; lookup sees newest.
    evict(32'h100, 128'hA1);
    evict(32'h100, 128'hB1);
    chk("lit_t4_count", 128'(count), 128'd2);
    lookup_addr = 32'h100;
    #1;
    chk("lit_t4_newest", lookup_data, 128'hB1);
    mem_ready = 1'b1;
    #1;
    chk("lit_t4_first", mem_data, 128'hA1);
    step();
    chk("lit_t4_second", mem_data, 128'hB1);
    step();
    chk("lit_t4_empty", 128'(count), 128'd0);
    mem_ready   = 1'b0;
    lookup_addr = '0;

    // Flush with a colliding eviction, then flush while empty.
    evict(32'h600, 128'h61);
    evict(32'h610, 128'h62);
    flush_req = 1'b1;
    wb_valid  = 1'b1;
    wb_addr   = 32'h700;
    wb_data   = 128'h70;
    #1;
    chk("lit_t5_refused", 128'(wb_ready), 128'd0);
    step();
    flush_req = 1'b0;
    wb_valid  = 1'b0;
    chk("lit_t5_count", 128'(count),      128'd2);
    chk("lit_t5_nodone", 128'(flush_done), 128'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) step();
    chk("lit_t5_done",   128'(flush_done), 128'd1);
    step();
    chk("lit_t5_pulse",  128'(flush_done), 128'd0);
    chk("lit_t5_idle",   128'(wb_ready),   128'd1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("lit_t5_empty_done", 128'(flush_done), 128'd1);
    step();
    chk("lit_t5_empty_pulse", 128'(flush_done), 128'd0);
    mem_ready = 1'b0;

    // Asynchronous reset mid-drain.
    evict(32'h800, 128'h81);
    evict(32'h810, 128'h82);
    evict(32'h820, 128'h83);
    mem_ready   = 1'b1;
    lookup_addr = 32'h810;
    step();
    chk("lit_t6_pre_hit", 128'(lookup_hit),   128'd1);
    chk("lit_t6_pre_err", 128'(err_overflow), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_t6_count", 128'(count),        128'd0);
    chk("lit_t6_wr_en", 128'(mem_wr_en),    128'd0);
    chk("lit_t6_hit",   128'(lookup_hit),   128'd0);
    chk("lit_t6_err",   128'(err_overflow), 128'd0);
    step();
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
